touch_key_ctrl: RTL

Sequencing controller for the three on-screen touch keys (open/close, play/pause, clear) of the counter UI. It hit-tests sampled touch coordinates against the key rectangles and debounces presses. It fires one action per press, holds the open and play state registers, and generates the clear pulse. The highlight output feeds the key-drawing block. The state outputs feed the camera/counter control path.

---
 rtl/touch_key_pkg.sv | 38 +++
 rtl/key_hit_test.sv | 33 +++
 rtl/touch_key_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/touch_key_pkg.sv
// Shared definitions for the touch-key controller and the key-drawing block:
// FSM states, key identifiers and the default on-screen key geometry.
package touch_key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HOLD = 2'd2
  } key_state_e;

  localparam logic [1:0] KEY_NONE = 2'd0;
  localparam logic [1:0] KEY_OPCL = 2'd1;
  localparam logic [1:0] KEY_PLPA = 2'd2;
  localparam logic [1:0] KEY_CLR  = 2'd3;

  localparam logic [10:0] DEF_X1 = 11'd11;
  localparam logic [10:0] DEF_X2 = 11'd100;
  localparam logic [10:0] DEF_X3 = 11'd121;
  localparam logic [10:0] DEF_X4 = 11'd210;
  localparam logic [10:0] DEF_X5 = 11'd231;
  localparam logic [10:0] DEF_X6 = 11'd320;
  localparam logic [9:0]  DEF_Y1 = 10'd11;
  localparam logic [9:0]  DEF_Y2 = 10'd90;

  // Highlight bit for a key id; bit0 belongs to key 1.
  function automatic logic [2:0] key_onehot(input logic [1:0] id);
    logic [2:0] hl;
    hl = 3'b000;
    case (id)
      KEY_OPCL: hl = 3'b001;
      KEY_PLPA: hl = 3'b010;
      KEY_CLR:  hl = 3'b100;
      default:  hl = 3'b000;
    endcase
    return hl;
  endfunction

endpackage

// File: rtl/key_hit_test.sv
// Combinational hit test: maps a touch coordinate to the key it lies on
// (KEY_NONE when outside every key rectangle).
module key_hit_test
  import touch_key_pkg::*;
#(
  parameter logic [10:0] X1 = DEF_X1,
  parameter logic [10:0] X2 = DEF_X2,
  parameter logic [10:0] X3 = DEF_X3,
  parameter logic [10:0] X4 = DEF_X4,
  parameter logic [10:0] X5 = DEF_X5,
  parameter logic [10:0] X6 = DEF_X6,
  parameter logic [9:0]  Y1 = DEF_Y1,
  parameter logic [9:0]  Y2 = DEF_Y2
) (
  input  logic [10:0] x_i,
  input  logic [9:0]  y_i,
  output logic [1:0]  cls_o
);

  logic inRow;

  // Later assignments override earlier ones, so overlapping keys resolve to the lowest index.
  always_comb begin
    inRow = (y_i >= Y1) && (y_i <= Y2);
    cls_o = KEY_NONE;
    if (inRow) begin
      if ((x_i >= X5) && (x_i <= X6)) cls_o = KEY_CLR;
      if ((x_i >= X3) && (x_i <= X4)) cls_o = KEY_PLPA;
      if ((x_i >= X1) && (x_i <= X2)) cls_o = KEY_OPCL;
    end
  end

endmodule

// File: rtl/touch_key_ctrl.sv
// Touch-key sequencer: debounces presses on the three keys, fires one action
// per press and holds the open/play state plus the clear pulse.
module touch_key_ctrl
  import touch_key_pkg::*;
#(
  parameter logic [10:0] X1 = DEF_X1,
  parameter logic [10:0] X2 = DEF_X2,
  parameter logic [10:0] X3 = DEF_X3,
  parameter logic [10:0] X4 = DEF_X4,
  parameter logic [10:0] X5 = DEF_X5,
  parameter logic [10:0] X6 = DEF_X6,
  parameter logic [9:0]  Y1 = DEF_Y1,
  parameter logic [9:0]  Y2 = DEF_Y2,
  parameter int          DEBOUNCE = 4,
  parameter int          RELEASE  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        touch_valid,
  input  logic        touch_down,
  input  logic [10:0] touch_x,
  input  logic [9:0]  touch_y,
  output logic        out_op_cl,
  output logic        out_pl_pa,
  output logic        out_clear,
  output logic        key_evt,
  output logic [1:0]  key_id,
  output logic [2:0]  key_hl
);

  localparam logic [3:0] DEB_LIM = 4'(DEBOUNCE);
  localparam logic [3:0] REL_LIM = 4'(RELEASE);

  key_state_e state_q, state_d;
  logic [1:0] cand_q, cand_d, id_q, id_d, hitCls;
  logic [3:0] cnt_q, cnt_d, rcnt_q, rcnt_d;
  logic       opcl_q, opcl_d, plpa_q, plpa_d, clear_q, clear_d, evt_q, evt_d;
  logic [2:0] hl_q, hl_d;
  logic       fire;

  key_hit_test #(
    .X1(X1), .X2(X2), .X3(X3), .X4(X4), .X5(X5), .X6(X6), .Y1(Y1), .Y2(Y2)
  ) u_hit (
    .x_i   (touch_x),
    .y_i   (touch_y),
    .cls_o (hitCls)
  );

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    fire    = 1'b0;
    if (touch_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (touch_down && (hitCls != KEY_NONE)) begin
            cand_d  = hitCls;
            cnt_d   = 4'd1;
            state_d = ST_ARM;
          end
        end
        ST_ARM: begin
          if (touch_down && (hitCls == cand_q)) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == DEB_LIM) begin
              fire    = 1'b1;
              rcnt_d  = 4'd0;
              state_d = ST_HOLD;
            end
          end else if (touch_down && (hitCls != KEY_NONE)) begin
            cand_d = hitCls;
            cnt_d  = 4'd1;
          end else begin
            cnt_d   = 4'd0;
            state_d = ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (!touch_down) begin
            rcnt_d = rcnt_q + 4'd1;
            if (rcnt_q + 4'd1 == REL_LIM) begin
              rcnt_d  = 4'd0;
              cnt_d   = 4'd0;
              state_d = ST_IDLE;
            end
          end else begin
            rcnt_d = 4'd0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Action decode for a fired press; closing also forces pause on the same edge.
  always_comb begin
    opcl_d  = opcl_q;
    plpa_d  = plpa_q;
    id_d    = id_q;
    clear_d = 1'b0;
    evt_d   = 1'b0;
    if (fire) begin
      evt_d = 1'b1;
      id_d  = cand_q;
      case (cand_q)
        KEY_OPCL: begin
          opcl_d = ~opcl_q;
          if (opcl_q) plpa_d = 1'b0;
        end
        KEY_PLPA: if (opcl_q) plpa_d = ~plpa_q;
        KEY_CLR:  clear_d = 1'b1;
        default:  ;
      endcase
    end
    hl_d = (state_d == ST_IDLE) ? 3'b000 : key_onehot(cand_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cand_q  <= KEY_NONE;
      cnt_q   <= 4'd0;
      rcnt_q  <= 4'd0;
      opcl_q  <= 1'b0;
      plpa_q  <= 1'b0;
      clear_q <= 1'b0;
      evt_q   <= 1'b0;
      id_q    <= KEY_NONE;
      hl_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      opcl_q  <= opcl_d;
      plpa_q  <= plpa_d;
      clear_q <= clear_d;
      evt_q   <= evt_d;
      id_q    <= id_d;
      hl_q    <= hl_d;
    end
  end

  assign out_op_cl = opcl_q;
  assign out_pl_pa = plpa_q;
  assign out_clear = clear_q;
  assign key_evt   = evt_q;
  assign key_id    = id_q;
  assign key_hl    = hl_q;

endmodule
